// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stage mode encodings and the occupancy-width helper
// used by the stage FIFO, the decoder and the hazard unit.
package pipe_pkg;

  localparam logic [1:0] CTR_RUN   = 2'b00;
  localparam logic [1:0] CTR_HOLD  = 2'b01;
  localparam logic [1:0] CTR_FLUSH = 2'b10;
  localparam logic [1:0] CTR_DRAIN = 2'b11;

  // Bits needed to count 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_ring_ptr.sv
// Modulo-DEPTH ring pointer with synchronous clear; wraps DEPTH-1 -> 0, so DEPTH need not
// be a power of two.
module pipe_ring_ptr #(
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage: DEPTH-entry flop FIFO with valid/ready on both sides and
// per-stage RUN / HOLD / FLUSH / DRAIN control.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 2,
  parameter int FLUSH_ZERO = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                ctr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy,
  output logic                      flushed
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready depends only on mode and count (never on out_ready); out_valid depends only on
  // mode and count (never on in_valid), so neither side sees a combinational loop.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = occ_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [OW-1:0]    count_q, count_d;
  logic             flushed_q, flushed_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             is_run, is_flush, is_drain;
  logic             push, pop;

  assign is_run   = (ctr == CTR_RUN);
  assign is_flush = (ctr == CTR_FLUSH);
  assign is_drain = (ctr == CTR_DRAIN);

  // rst gates in_ready so the stage refuses input while held in reset.
  assign in_ready  = rst && is_run && (count_q < OW'(DEPTH));
  assign out_valid = (count_q != '0) && (is_run || is_drain);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d     = mem_q;
    count_d   = count_q;
    flushed_d = 1'b0;
    if (is_flush) begin
      count_d   = '0;
      flushed_d = (count_q != '0);
      if (FLUSH_ZERO != 0) begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      end
    end else begin
      if (push) mem_d[wr_ptr] = in_data;
      case ({push, pop})
        2'b10:   count_d = count_q + OW'(1);
        2'b01:   count_d = count_q - OW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q   <= '0;
      flushed_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      count_q   <= count_d;
      flushed_q <= flushed_d;
    end
  end

  pipe_ring_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .clr (is_flush),
    .ptr (wr_ptr)
  );

  pipe_ring_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .clr (is_flush),
    .ptr (rd_ptr)
  );

  assign out_data  = mem_q[rd_ptr];
  assign occupancy = count_q;
  assign flushed   = flushed_q;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: a DEPTH=2 and a DEPTH=3 instance, each checked every cycle
// against a queue-based reference model, plus literal expectations from directed scenarios.
module tb_pipe_stage_fifo;
  import pipe_pkg::*;

  logic clk;
  logic rst;

  logic [1:0]  ctr2, ctr3;
  logic        iv2, iv3, ir2, ir3, ov2, ov3, or2, or3, fl2, fl3;
  logic [63:0] id2, id3, od2, od3;
  logic [1:0]  occ2, occ3;

  int tests_run = 0;
  int failed    = 0;

  logic [63:0] q2[$];
  logic [63:0] q3[$];
  logic        fexp2, fexp3;
  logic [63:0] got2[$];
  logic [63:0] got3[$];

  pipe_stage_fifo #(.WIDTH(64), .DEPTH(2), .FLUSH_ZERO(1)) d2 (
    .clk(clk), .rst(rst), .ctr(ctr2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(occ2), .flushed(fl2)
  );

  pipe_stage_fifo #(.WIDTH(64), .DEPTH(3), .FLUSH_ZERO(1)) d3 (
    .clk(clk), .rst(rst), .ctr(ctr3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(occ3), .flushed(fl3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard primitives
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int depth, input logic [1:0] c,
                           input int qsz, input logic [63:0] head, input logic fexp,
                           input logic ir, input logic ov, input logic [63:0] od,
                           input logic [1:0] occ, input logic fl);
    logic e_ir, e_ov;
    e_ir = rst && (c == CTR_RUN) && (qsz < depth);
    e_ov = (qsz != 0) && (c == CTR_RUN || c == CTR_DRAIN);
    chk({tag, ".in_ready"},  64'(ir),  64'(e_ir));
    chk({tag, ".out_valid"}, 64'(ov),  64'(e_ov));
    chk({tag, ".occupancy"}, 64'(occ), 64'(qsz));
    chk({tag, ".flushed"},   64'(fl),  64'(fexp));
    if (qsz != 0) chk({tag, ".out_data"}, od, head);
  endtask

  // One cycle: compare at negedge, advance the reference models on posedge, return at +1.
  task automatic tick();
    int  sz;
    logic pu, po;
    @(negedge clk);
    check_dut("d2", 2, ctr2, q2.size(), (q2.size() != 0) ? q2[0] : 64'h0, fexp2,
              ir2, ov2, od2, occ2, fl2);
    check_dut("d3", 3, ctr3, q3.size(), (q3.size() != 0) ? q3[0] : 64'h0, fexp3,
              ir3, ov3, od3, occ3, fl3);
    if (ov2 && or2) got2.push_back(od2);
    if (ov3 && or3) got3.push_back(od3);
    @(posedge clk);
    sz = q2.size();
    pu = iv2 && rst && (ctr2 == CTR_RUN) && (sz < 2);
    po = (sz != 0) && (ctr2 == CTR_RUN || ctr2 == CTR_DRAIN) && or2;
    if (!rst) begin q2.delete(); fexp2 = 1'b0; end
    else if (ctr2 == CTR_FLUSH) begin fexp2 = (sz != 0); q2.delete(); end
    else begin
      fexp2 = 1'b0;
      if (po) void'(q2.pop_front());
      if (pu) q2.push_back(id2);
    end
    sz = q3.size();
    pu = iv3 && rst && (ctr3 == CTR_RUN) && (sz < 3);
    po = (sz != 0) && (ctr3 == CTR_RUN || ctr3 == CTR_DRAIN) && or3;
    if (!rst) begin q3.delete(); fexp3 = 1'b0; end
    else if (ctr3 == CTR_FLUSH) begin fexp3 = (sz != 0); q3.delete(); end
    else begin
      fexp3 = 1'b0;
      if (po) void'(q3.pop_front());
      if (pu) q3.push_back(id3);
    end
    #1;
  endtask

  task automatic push2(input logic [63:0] v);
    iv2 = 1'b1; id2 = v; tick(); iv2 = 1'b0;
  endtask

  task automatic push3(input logic [63:0] v);
    iv3 = 1'b1; id3 = v; tick(); iv3 = 1'b0;
  endtask

  // Stimulus
  initial begin
    int bad;
    rst = 1'b0;
    ctr2 = CTR_RUN; ctr3 = CTR_RUN;
    iv2 = 0; iv3 = 0; or2 = 0; or3 = 0; id2 = '0; id3 = '0;
    fexp2 = 0; fexp3 = 0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Async reset mid-stream with two entries stored
    push2(64'h11); push2(64'h22);
    chk("t1.occ_before_reset", 64'(occ2), 64'd2);
    rst = 1'b0;
    #1;
    chk("t1.out_valid_in_reset", 64'(ov2), 64'd0);
    chk("t1.occ_in_reset", 64'(occ2), 64'd0);
    chk("t1.out_data_in_reset", od2, 64'h0);
    chk("t1.in_ready_in_reset", 64'(ir2), 64'd0);
    q2.delete(); q3.delete(); fexp2 = 0; fexp3 = 0;
    tick();
    rst = 1'b1;
    push2(64'hA5);
    chk("t1.first_push_valid", 64'(ov2), 64'd1);
    chk("t1.first_push_data", od2, 64'hA5);
    or2 = 1'b1; tick(); or2 = 1'b0;

    // Back-to-back streaming at DEPTH=2
    got2.delete();
    or2 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      iv2 = 1'b1; id2 = 64'(i); tick();
    end
    iv2 = 1'b0;
    tick(); tick();
    or2 = 1'b0;
    chk("t2.count", 64'(got2.size()), 64'd100);
    bad = 0;
    for (int i = 0; i < got2.size(); i++) if (got2[i] !== 64'(i)) bad++;
    chk("t2.order_errors", 64'(bad), 64'd0);

    // Backpressure and pointer wrap at DEPTH=3
    got3.delete();
    push3(64'd1); push3(64'd2); push3(64'd3);
    chk("t3.full_in_ready", 64'(ir3), 64'd0);
    chk("t3.full_occ", 64'(occ3), 64'd3);
    chk("t3.wr_ptr_wrapped", 64'(d3.wr_ptr), 64'd0);
    iv3 = 1'b1; id3 = 64'h99; or3 = 1'b1;
    #1;
    chk("t3.full_pop_in_ready", 64'(ir3), 64'd0);
    tick();
    or3 = 1'b0; id3 = 64'd4;
    tick();
    iv3 = 1'b0;
    chk("t3.wr_ptr_after_4", 64'(d3.wr_ptr), 64'd1);
    or3 = 1'b1; tick(); tick(); tick(); or3 = 1'b0;
    chk("t3.count", 64'(got3.size()), 64'd4);
    bad = 0;
    for (int i = 0; i < got3.size(); i++) if (got3[i] !== 64'(i + 1)) bad++;
    chk("t3.order_errors", 64'(bad), 64'd0);

    // HOLD at count=2
    push2(64'h100); push2(64'h200);
    ctr2 = CTR_HOLD; iv2 = 1'b1; id2 = 64'hDEAD; or2 = 1'b1;
    #1;
    chk("t4.hold_in_ready", 64'(ir2), 64'd0);
    chk("t4.hold_out_valid", 64'(ov2), 64'd0);
    repeat (5) tick();
    chk("t4.hold_occ", 64'(occ2), 64'd2);
    ctr2 = CTR_RUN; iv2 = 1'b0; or2 = 1'b0;
    #1;
    chk("t4.resume_valid", 64'(ov2), 64'd1);
    chk("t4.resume_head", od2, 64'h100);

    // FLUSH at count=2, then FLUSH when empty
    ctr2 = CTR_FLUSH;
    tick();
    chk("t5.flush_occ", 64'(occ2), 64'd0);
    chk("t5.flush_pulse", 64'(fl2), 64'd1);
    chk("t5.flush_out_data", od2, 64'h0);
    for (int i = 0; i < 2; i++) chk("t5.mem_zero", d2.mem_q[i], 64'h0);
    tick();
    chk("t5.flush_held_no_pulse", 64'(fl2), 64'd0);
    ctr2 = CTR_RUN; tick();
    ctr2 = CTR_FLUSH; tick();
    chk("t5.flush_empty_no_pulse", 64'(fl2), 64'd0);
    ctr2 = CTR_RUN; tick();

    // DRAIN at count=2 with upstream still offering data
    push2(64'h33); push2(64'h44);
    got2.delete();
    ctr2 = CTR_DRAIN; iv2 = 1'b1; id2 = 64'h55; or2 = 1'b1;
    #1;
    chk("t6.drain_in_ready", 64'(ir2), 64'd0);
    tick(); tick();
    chk("t6.drain_occ", 64'(occ2), 64'd0);
    chk("t6.drain_count", 64'(got2.size()), 64'd2);
    if (got2.size() == 2) begin
      chk("t6.drain_first", got2[0], 64'h33);
      chk("t6.drain_second", got2[1], 64'h44);
    end
    iv2 = 1'b0; or2 = 1'b0; ctr2 = CTR_RUN;
    tick();

    // Random modes against the reference model
    for (int n = 0; n < 400; n++) begin
      int r2, r3;
      r2 = int'($urandom_range(0, 9));
      r3 = int'($urandom_range(0, 9));
      ctr2 = (r2 < 6) ? CTR_RUN : (r2 == 6) ? CTR_HOLD : (r2 == 7) ? CTR_FLUSH : CTR_DRAIN;
      ctr3 = (r3 < 6) ? CTR_RUN : (r3 == 6) ? CTR_HOLD : (r3 == 7) ? CTR_FLUSH : CTR_DRAIN;
      iv2 = 1'($urandom_range(0, 1)); or2 = 1'($urandom_range(0, 1));
      iv3 = 1'($urandom_range(0, 1)); or3 = 1'($urandom_range(0, 1));
      id2 = {$urandom, $urandom};
      id3 = {$urandom, $urandom};
      tick();
    end
    ctr2 = CTR_RUN; ctr3 = CTR_RUN; iv2 = 0; iv3 = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
